// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor
// Description : Direct-mapped branch target buffer with a 2-bit saturating
//               direction counter per entry and a registered prediction port.
// Revision    : 1.0 - initial release
// ============================================================================
module btb_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        lookup_req,
    input  logic [31:0] lookup_pc,
    input  logic        stall,
    output logic        pred_valid,
    output logic [31:0] pred_pc,
    output logic        pred_hit,
    output logic        predicted_outcome,
    output logic [31:0] pred_target,
    input  logic        update_btb,
    input  logic [31:0] update_pc,
    input  logic        branch_outcome,
    input  logic [31:0] branch_target,
    input  logic        btb_clear,
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_hits
);

    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic             w_lk_taken;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;

    assign w_lk_idx   = lookup_pc[IDX_W+1:2];
    assign w_lk_tag   = lookup_pc[31:IDX_W+2];
    assign w_lk_hit   = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    assign w_lk_taken = w_lk_hit && ctr_q[w_lk_idx][1];

    assign w_up_idx   = update_pc[IDX_W+1:2];
    assign w_up_tag   = update_pc[31:IDX_W+2];
    assign w_up_hit   = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);

    // Table: reset beats clear, clear beats update. Lookups read the
    // registered state, so a same-cycle update is seen only next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (btb_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (update_btb) begin
            if (w_up_hit) begin
                if (branch_outcome) begin
                    if (ctr_q[w_up_idx] != 2'b11) begin
                        ctr_q[w_up_idx] <= ctr_q[w_up_idx] + 2'd1;
                    end
                    target_q[w_up_idx] <= branch_target;
                end else if (ctr_q[w_up_idx] != 2'b00) begin
                    ctr_q[w_up_idx] <= ctr_q[w_up_idx] - 2'd1;
                end
            end else if (branch_outcome) begin
                // Only taken branches earn an entry.
                valid_q[w_up_idx]  <= 1'b1;
                tag_q[w_up_idx]    <= w_up_tag;
                target_q[w_up_idx] <= branch_target;
                ctr_q[w_up_idx]    <= 2'b10;
            end
        end
    end

    logic        pred_valid_q,  pred_valid_d;
    logic [31:0] pred_pc_q,     pred_pc_d;
    logic        pred_hit_q,    pred_hit_d;
    logic        pred_taken_q,  pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;
    logic [31:0] lookups_q,     lookups_d;
    logic [31:0] hits_q,        hits_d;

    always_comb begin
        pred_valid_d  = pred_valid_q;
        pred_pc_d     = pred_pc_q;
        pred_hit_d    = pred_hit_q;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        lookups_d     = lookups_q;
        hits_d        = hits_q;
        if (!stall) begin
            if (lookup_req) begin
                pred_valid_d  = 1'b1;
                pred_pc_d     = lookup_pc;
                pred_hit_d    = w_lk_hit;
                pred_taken_d  = w_lk_taken;
                pred_target_d = w_lk_taken ? target_q[w_lk_idx] : lookup_pc + 32'd4;
                lookups_d     = lookups_q + 32'd1;
                hits_d        = hits_q + {31'd0, w_lk_hit};
            end else begin
                pred_valid_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pred_valid_q  <= 1'b0;
            pred_pc_q     <= '0;
            pred_hit_q    <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
            lookups_q     <= '0;
            hits_q        <= '0;
        end else begin
            pred_valid_q  <= pred_valid_d;
            pred_pc_q     <= pred_pc_d;
            pred_hit_q    <= pred_hit_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
            lookups_q     <= lookups_d;
            hits_q        <= hits_d;
        end
    end

    assign pred_valid        = pred_valid_q;
    assign pred_pc           = pred_pc_q;
    assign pred_hit          = pred_hit_q;
    assign predicted_outcome = pred_taken_q;
    assign pred_target       = pred_target_q;
    assign perf_lookups      = lookups_q;
    assign perf_hits         = hits_q;

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_predictor
// Description : Directed self-checking bench for btb_predictor (ENTRIES=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btb_predictor;

    logic        CLK = 1'b0;
    logic        RST;
    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic        stall;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        predicted_outcome;
    logic [31:0] pred_target;
    logic        update_btb;
    logic [31:0] update_pc;
    logic        branch_outcome;
    logic [31:0] branch_target;
    logic        btb_clear;
    logic [31:0] perf_lookups;
    logic [31:0] perf_hits;

    int n_pass  = 0;
    int n_total = 0;

    btb_predictor #(.ENTRIES(16)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .lookup_req        (lookup_req),
        .lookup_pc         (lookup_pc),
        .stall             (stall),
        .pred_valid        (pred_valid),
        .pred_pc           (pred_pc),
        .pred_hit          (pred_hit),
        .predicted_outcome (predicted_outcome),
        .pred_target       (pred_target),
        .update_btb        (update_btb),
        .update_pc         (update_pc),
        .branch_outcome    (branch_outcome),
        .branch_target     (branch_target),
        .btb_clear         (btb_clear),
        .perf_lookups      (perf_lookups),
        .perf_hits         (perf_hits)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_req = 1'b1;
        lookup_pc  = pc;
        step();
        lookup_req = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        update_btb     = 1'b1;
        update_pc      = pc;
        branch_outcome = taken;
        branch_target  = tgt;
        step();
        update_btb     = 1'b0;
    endtask

    task automatic pred(input string tag, input logic [31:0] pc, input logic hit,
                        input logic taken, input logic [31:0] tgt);
        chk({tag, "_valid"},  {31'd0, pred_valid},        32'd1);
        chk({tag, "_pc"},     pred_pc,                    pc);
        chk({tag, "_hit"},    {31'd0, pred_hit},          {31'd0, hit});
        chk({tag, "_taken"},  {31'd0, predicted_outcome}, {31'd0, taken});
        chk({tag, "_target"}, pred_target,                tgt);
    endtask

    task automatic perf(input string tag, input logic [31:0] l, input logic [31:0] h);
        chk({tag, "_lookups"}, perf_lookups, l);
        chk({tag, "_hits"},    perf_hits,    h);
    endtask

    initial begin
        RST = 1'b1; lookup_req = 1'b0; lookup_pc = '0; stall = 1'b0;
        update_btb = 1'b0; update_pc = '0; branch_outcome = 1'b0;
        branch_target = '0; btb_clear = 1'b0;
        step(); step();
        RST = 1'b0;
        chk("rst_valid",  {31'd0, pred_valid},        32'd0);
        chk("rst_pc",     pred_pc,                    32'd0);
        chk("rst_hit",    {31'd0, pred_hit},          32'd0);
        chk("rst_taken",  {31'd0, predicted_outcome}, 32'd0);
        chk("rst_target", pred_target,                32'd0);
        perf("rst", 0, 0);

        look(32'h100);
        pred("cold", 32'h100, 1'b0, 1'b0, 32'h104);
        perf("cold", 1, 0);

        // Lookup and first taken update in the same cycle: read-before-write.
        update_btb = 1'b1; update_pc = 32'h100; branch_outcome = 1'b1;
        branch_target = 32'h200;
        look(32'h100);
        update_btb = 1'b0;
        pred("rbw", 32'h100, 1'b0, 1'b0, 32'h104);
        look(32'h100);
        pred("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        perf("alloc", 3, 1);

        step();
        chk("idle_valid",  {31'd0, pred_valid}, 32'd0);
        chk("idle_pc",     pred_pc,             32'h100);
        chk("idle_target", pred_target,         32'h200);

        // Counter walk: 10 -> 01 -> 00 -> 00 (saturate low)
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100);
        pred("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h200);
        look(32'h100);
        pred("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h200);
        look(32'h100);
        pred("ctr10", 32'h100, 1'b1, 1'b1, 32'h200);
        // 10 -> 11 -> 11 (saturate high) -> 10 still taken -> 01 not taken
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100);
        pred("ctr11_10", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0);
        look(32'h100);
        pred("ctr01b", 32'h100, 1'b1, 1'b0, 32'h104);
        perf("walk", 8, 6);

        upd(32'h100, 1'b1, 32'h240);
        look(32'h100);
        pred("retarget", 32'h100, 1'b1, 1'b1, 32'h240);

        // Aliasing on index 0
        upd(32'h140, 1'b1, 32'h300);
        look(32'h100);
        pred("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        look(32'h140);
        pred("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
        upd(32'h180, 1'b0, 32'h0);
        look(32'h140);
        pred("nt_noalloc", 32'h140, 1'b1, 1'b1, 32'h300);
        look(32'h180);
        pred("nt_miss", 32'h180, 1'b0, 1'b0, 32'h184);
        perf("alias", 13, 9);

        upd(32'h104, 1'b1, 32'h500);
        look(32'h104);
        pred("idx1", 32'h104, 1'b1, 1'b1, 32'h500);
        look(32'hFFFF_FFFC);
        pred("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        perf("wrap", 15, 10);

        // Stall freezes outputs and counters
        look(32'h140);
        lookup_req = 1'b1;
        stall      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lookup_pc = 32'h104 + 32'(k) * 32'h10;
            step();
            pred("stall", 32'h140, 1'b1, 1'b1, 32'h300);
        end
        stall      = 1'b0;
        lookup_req = 1'b0;
        perf("stall", 16, 11);

        // Clear: same-cycle lookup sees pre-clear state, same-cycle update dropped
        btb_clear = 1'b1;
        update_btb = 1'b1; update_pc = 32'h1C0; branch_outcome = 1'b1;
        branch_target = 32'h700;
        look(32'h140);
        btb_clear = 1'b0; update_btb = 1'b0;
        pred("clr_pre", 32'h140, 1'b1, 1'b1, 32'h300);
        look(32'h140);
        pred("clr_140", 32'h140, 1'b0, 1'b0, 32'h144);
        look(32'h1C0);
        pred("clr_drop", 32'h1C0, 1'b0, 1'b0, 32'h1C4);
        look(32'h104);
        pred("clr_104", 32'h104, 1'b0, 1'b0, 32'h108);
        perf("clr", 20, 12);

        // Reset overrides a same-cycle update
        RST = 1'b1;
        upd(32'h100, 1'b1, 32'h900);
        RST = 1'b0;
        chk("rst2_valid",  {31'd0, pred_valid}, 32'd0);
        chk("rst2_pc",     pred_pc,             32'd0);
        chk("rst2_target", pred_target,         32'd0);
        perf("rst2", 0, 0);
        look(32'h100);
        pred("rst2_look", 32'h100, 1'b0, 1'b0, 32'h104);
        perf("rst2_look", 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Fetch-side branch target buffer with a 2-bit saturating direction predictor per entry.
- Supplies predicted_outcome and target to the fetch stage, one cycle after a lookup request.
- Consumes branch-resolution updates from the branch functional unit: update_btb, update_pc, branch_outcome, branch_target.
- Closes the predict/resolve loop between fetch and the branch FU.

Parameters:
- ENTRIES, 16, number of direct-mapped entries; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; derived, do not override.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- lookup_req  in  1  fetch requests a prediction for lookup_pc.
- lookup_pc  in  32  fetch PC, word aligned.
- stall  in  1  fetch stalled; hold prediction outputs.
- pred_valid  out  1  prediction outputs are valid.
- pred_pc  out  32  PC the prediction belongs to.
- pred_hit  out  1  lookup matched a valid entry.
- predicted_outcome  out  1  predicted taken.
- pred_target  out  32  next fetch PC.
- update_btb  in  1  resolved conditional branch update strobe.
- update_pc  in  32  PC of the resolved branch.
- branch_outcome  in  1  actual direction.
- branch_target  in  32  taken target (pc+imm).
- btb_clear  in  1  invalidate all entries.
- perf_lookups  out  32  accepted lookups, wraps.
- perf_hits  out  32  lookups that hit, wraps.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
  - pc[1:0] ignored.
- Entry state: valid, tag, target[31:0], ctr[1:0].
  - ctr encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Reset (RST high at a CLK edge):
  - All entries: valid=0, ctr=01.
  - Outputs: pred_valid=0, pred_pc=0, pred_hit=0, predicted_outcome=0, pred_target=0, perf_lookups=0, perf_hits=0.
  - RST overrides every other input in the same cycle. RST mid-update discards that update.
- Lookup, latency 1:
  - Request accepted at edge N when lookup_req=1 and stall=0.
  - At edge N the output register loads:
    - pred_valid=1, pred_pc=lookup_pc.
    - hit = valid && tag match.
    - predicted_outcome = hit && ctr[1].
    - pred_target = predicted_outcome ? entry target : lookup_pc+4.
  - lookup_req=0 and stall=0: pred_valid=0 next cycle; other output fields hold.
  - stall=1: all prediction outputs hold regardless of lookup_req. Perf counters do not count.
- Update (update_btb=1 at edge), hit case (valid && tag match):
  - ctr saturating: +1 if taken (max 11), -1 if not (min 00).
  - target <= branch_target when taken.
- Update, miss case (invalid or tag mismatch):
  - taken: allocate/replace with valid=1, tag, target=branch_target, ctr=10.
  - not taken: no change (no allocation of not-taken branches).
- Same-cycle lookup and update to the same index: lookup sees pre-update state (read-before-write). The update is still applied.
- btb_clear=1 at an edge:
  - All valid<=0; ctr untouched.
  - A same-cycle update is dropped.
  - A same-cycle lookup is evaluated against the pre-clear state.
- Perf counters:
  - perf_lookups +1 per accepted lookup.
  - perf_hits +1 per accepted lookup with hit.
  - Both 32-bit, wrap 0xFFFFFFFF->0.
- Adding 4 to the PC wraps modulo 2^32.
- Table storage is flops; no RAM macro required.

Test Plan:
- Reset, then lookup 0x100 -> next cycle pred_valid=1, pred_hit=0, predicted_outcome=0, pred_target=0x104, perf_lookups=1, perf_hits=0.
- Update pc=0x100 taken target=0x200, then lookup 0x100 -> pred_hit=1, predicted_outcome=1 (ctr=10), pred_target=0x200.
- Update 0x100 not-taken twice from ctr=10 -> ctr=00; lookup -> predicted_outcome=0, pred_target=0x104. Three taken updates -> ctr=11; a fourth taken update stays 11.
- Aliasing with ENTRIES=16: allocate 0x100 taken (index 0), then update 0x140 taken target=0x300 (also index 0) -> lookup 0x100 misses, lookup 0x140 hits with target 0x300. Update 0x180 not-taken -> entry unchanged.
- Same-cycle lookup and first taken update of 0x100 -> that lookup reports a miss (target 0x104); the following lookup hits (target 0x200).
- stall=1 for 3 cycles with lookup_req=1 and varying lookup_pc -> outputs frozen, perf_lookups unchanged. btb_clear -> all lookups miss. RST asserted with update_btb=1 -> table invalid, all outputs 0.
